// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Results saturate to all nines when the value does not fit in DIGITS digits.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_r;
    logic [BIN_W-1:0]   shift_r;
    logic [BCD_W-1:0]   scratch_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               overflow_r;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   scratch_next_s;
    logic [BIN_W-1:0]   shift_next_s;
    logic               ovf_next_s;
    logic               last_s;

    function automatic logic [3:0] dabble(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= 4'd5) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

    // One conversion step: add-3 correction on every digit, then shift the combined register.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj_s[4*i +: 4] = dabble(scratch_r[4*i +: 4]);
        end
        scratch_next_s = {adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
        shift_next_s   = {shift_r[BIN_W-2:0], 1'b0};
        // A one leaving the MSD means the running value already reached 10^DIGITS.
        ovf_next_s     = ovf_r | adj_s[BCD_W-1];
        last_s         = (cnt_r == CNT_W'(BIN_W - 1));
    end

    // Control FSM with datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            scratch_r  <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && !busy_r) begin
                        shift_r   <= bin_in;
                        scratch_r <= '0;
                        ovf_r     <= 1'b0;
                        cnt_r     <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= CONV;
                    end
                end
                CONV: begin
                    shift_r   <= shift_next_s;
                    scratch_r <= scratch_next_s;
                    ovf_r     <= ovf_next_s;
                    cnt_r     <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        bcd_r      <= ovf_next_s ? ALL_NINES : scratch_next_s;
                        overflow_r <= ovf_next_s;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd_out  = bcd_r;
    assign overflow = overflow_r;

endmodule
